// File: rtl/period_cal_sequencer_if.sv
// Signal bundle between the calibration sequencer, its start/abort controller and the
// period measurer. start/abort/cal_upd are one-cycle pulses with no back-pressure.
interface period_cal_sequencer_if #(
  parameter int COUNTBW = 20
);
  logic               start;
  logic               abort;
  logic               meas_init;
  logic               meas_locked;
  logic [COUNTBW-1:0] meas_h;
  logic [COUNTBW-1:0] meas_l;
  logic [COUNTBW-1:0] cal_h;
  logic [COUNTBW-1:0] cal_l;
  logic               cal_valid;
  logic               cal_upd;
  logic               busy;
  logic               err_timeout;
  logic               err_range;
  logic [1:0]         attempt;

  modport master (
    output start, abort, meas_locked, meas_h, meas_l,
    input  meas_init, cal_h, cal_l, cal_valid, cal_upd, busy,
           err_timeout, err_range, attempt
  );

  modport slave (
    input  start, abort, meas_locked, meas_h, meas_l,
    output meas_init, cal_h, cal_l, cal_valid, cal_upd, busy,
           err_timeout, err_range, attempt
  );
endinterface

// File: rtl/period_cal_sequencer.sv
// Sequences init/lock/range-check of the period measurer and publishes held calibration counts.
// Optional PERIOD_CAL_AUTO_RECAL_EN: automatic recalibration RECAL_PERIOD cycles after DONE.
module period_cal_sequencer #(
  parameter int COUNTBW      = 20,
  parameter int TMRBW        = 32,
  parameter int INIT_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 50000000,
  parameter int MAX_RETRY    = 3,
  parameter int MIN_COUNT    = 16,
  parameter int MAX_COUNT    = 1000000,
  parameter int RECAL_PERIOD = 500000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  period_cal_sequencer_if.slave  bus,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_CHECK     = 3'd3,
    S_DONE      = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [TMRBW-1:0]   INIT_LAST  = TMRBW'(INIT_CYCLES - 1);
  localparam logic [TMRBW-1:0]   LOCK_LAST  = TMRBW'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]         RETRY_LAST = 2'(MAX_RETRY);
  localparam logic [COUNTBW-1:0] MIN_C      = COUNTBW'(MIN_COUNT);
  localparam logic [COUNTBW-1:0] MAX_C      = COUNTBW'(MAX_COUNT);
`ifdef PERIOD_CAL_AUTO_RECAL_EN
  localparam logic [TMRBW-1:0]   RECAL_LAST = TMRBW'(RECAL_PERIOD - 1);
`endif

  state_t             state_q, state_d;
  logic [TMRBW-1:0]   timer_q, timer_d, timer_inc;
  logic [1:0]         attempt_q, attempt_d;
  logic [COUNTBW-1:0] cal_h_q, cal_h_d, cal_l_q, cal_l_d;
  logic [COUNTBW-1:0] samp_h_q, samp_h_d, samp_l_q, samp_l_d;
  logic               cal_valid_q, cal_valid_d;
  logic               cal_upd_q, cal_upd_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_range_q, err_range_d;
  logic               in_range;
  logic               restart;
  logic               fail_attempt;
  logic               fail_is_timeout;

  // Saturating increment: a stuck timer must never wrap back into a live compare value.
  assign timer_inc = (timer_q == {TMRBW{1'b1}}) ? timer_q : timer_q + 1'b1;

  assign in_range = (samp_h_q >= MIN_C) && (samp_h_q <= MAX_C) &&
                    (samp_l_q >= MIN_C) && (samp_l_q <= MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      attempt_q     <= '0;
      cal_h_q       <= '0;
      cal_l_q       <= '0;
      samp_h_q      <= '0;
      samp_l_q      <= '0;
      cal_valid_q   <= 1'b0;
      cal_upd_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      attempt_q     <= attempt_d;
      cal_h_q       <= cal_h_d;
      cal_l_q       <= cal_l_d;
      samp_h_q      <= samp_h_d;
      samp_l_q      <= samp_l_d;
      cal_valid_q   <= cal_valid_d;
      cal_upd_q     <= cal_upd_d;
      err_timeout_q <= err_timeout_d;
      err_range_q   <= err_range_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = '0;
    attempt_d       = attempt_q;
    cal_h_d         = cal_h_q;
    cal_l_d         = cal_l_q;
    samp_h_d        = samp_h_q;
    samp_l_d        = samp_l_q;
    cal_valid_d     = cal_valid_q;
    cal_upd_d       = 1'b0;
    err_timeout_d   = err_timeout_q;
    err_range_d     = err_range_q;
    restart         = 1'b0;
    fail_attempt    = 1'b0;
    fail_is_timeout = 1'b0;

    case (state_q)
      S_IDLE: restart = bus.start;
      S_INIT: begin
        if (timer_q == INIT_LAST) state_d = S_WAIT_LOCK;
        else                      timer_d = timer_inc;
      end
      S_WAIT_LOCK: begin
        timer_d = timer_inc;
        // Lock beats a same-cycle timeout; results are captured here while they are stable.
        if (bus.meas_locked) begin
          state_d  = S_CHECK;
          timer_d  = '0;
          samp_h_d = bus.meas_h;
          samp_l_d = bus.meas_l;
        end else if (timer_q == LOCK_LAST) begin
          fail_attempt    = 1'b1;
          fail_is_timeout = 1'b1;
        end
      end
      S_CHECK: begin
        if (in_range) begin
          state_d     = S_DONE;
          cal_h_d     = samp_h_q;
          cal_l_d     = samp_l_q;
          cal_valid_d = 1'b1;
          cal_upd_d   = 1'b1;
        end else begin
          fail_attempt = 1'b1;
        end
      end
      S_DONE: begin
`ifdef PERIOD_CAL_AUTO_RECAL_EN
        timer_d = timer_inc;
        restart = bus.start || (timer_q == RECAL_LAST);
`else
        restart = bus.start;
`endif
      end
      S_FAIL:  restart = bus.start;
      default: state_d = S_IDLE;
    endcase

    if (fail_attempt) begin
      timer_d = '0;
      if (attempt_q < RETRY_LAST) begin
        attempt_d = attempt_q + 2'd1;
        state_d   = S_INIT;
      end else begin
        state_d       = S_FAIL;
        err_timeout_d = fail_is_timeout;
        err_range_d   = !fail_is_timeout;
      end
    end

    if (restart) begin
      state_d       = S_INIT;
      timer_d       = '0;
      attempt_d     = '0;
      err_timeout_d = 1'b0;
      err_range_d   = 1'b0;
    end

    // Abort wins over everything, including a passing CHECK in the same cycle.
    if (bus.abort) begin
      state_d       = S_IDLE;
      timer_d       = '0;
      cal_h_d       = cal_h_q;
      cal_l_d       = cal_l_q;
      cal_valid_d   = cal_valid_q;
      cal_upd_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_range_d   = 1'b0;
    end
  end

  assign bus.meas_init   = (state_q == S_IDLE) || (state_q == S_INIT) || (state_q == S_FAIL);
  assign bus.busy        = (state_q == S_INIT) || (state_q == S_WAIT_LOCK) || (state_q == S_CHECK);
  assign bus.cal_h       = cal_h_q;
  assign bus.cal_l       = cal_l_q;
  assign bus.cal_valid   = cal_valid_q;
  assign bus.cal_upd     = cal_upd_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_range   = err_range_q;
  assign bus.attempt     = attempt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/period_cal_sequencer.md
Name: period_cal_sequencer

Overview:
- Controller that sequences one period-measurement/target-count datapath (inputs `init`, `locked`, `Diff_fre_h`/`Diff_fre_l`).
- Issues the measurement init pulse and waits for lock under a timeout.
- Range-checks both result counts, retries on failure, and publishes validated, held calibration counts to the downstream generator.
- Sits between the top-level control/start logic and the measurer.

Parameters:
- COUNTBW, 20: width of measurer result counts and calibrated outputs.
- TMRBW, 32: width of the internal wait/recal timer.
- INIT_CYCLES, 4: number of cycles `meas_init` is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000000: cycles allowed in WAIT_LOCK before an attempt fails.
- MAX_RETRY, 3: retries after the first attempt before declaring failure.
- MIN_COUNT, 16: inclusive lower bound for an acceptable count.
- MAX_COUNT, 1000000: inclusive upper bound for an acceptable count.
- RECAL_PERIOD, 500000000: cycles spent in DONE before automatic recalibration (feature-gated).

Ports:
- clk, in, 1: system clock; all logic on posedge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle request to begin calibration. Accepted only in IDLE, DONE or FAIL.
- abort, in, 1: returns the block to IDLE from any state. Takes priority over start.
- meas_init, out, 1: drives the measurer `init`.
- meas_locked, in, 1: measurer `locked`.
- meas_h, in, COUNTBW: measurer high-phase result.
- meas_l, in, COUNTBW: measurer low-phase result.
- cal_h, out, COUNTBW: last validated high count.
- cal_l, out, COUNTBW: last validated low count.
- cal_valid, out, 1: cal_h/cal_l hold a validated result. Sticky until reset.
- cal_upd, out, 1: one-cycle pulse when cal_h/cal_l are updated.
- busy, out, 1: high in INIT, WAIT_LOCK, CHECK.
- err_timeout, out, 1: final failure was a lock timeout.
- err_range, out, 1: final failure was an out-of-range result.
- attempt, out, 2: current attempt index, 0 = first attempt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - meas_init=1.
  - cal_h=cal_l=0.
  - cal_valid=cal_upd=busy=err_timeout=err_range=0.
  - attempt=0; timer=0.
- States:
  - IDLE:
    - meas_init=1.
    - On start: clear err_*, set attempt=0, go to INIT.
  - INIT:
    - meas_init=1 for exactly INIT_CYCLES cycles (timer counts).
    - Then timer=0, go to WAIT_LOCK.
  - WAIT_LOCK:
    - meas_init=0; timer increments each cycle.
    - If meas_locked=1, go to CHECK.
    - Else, if timer==LOCK_TIMEOUT-1, the attempt fails (timeout).
    - If lock and timeout occur in the same cycle, lock wins.
  - CHECK:
    - Sample meas_h/meas_l once.
    - Pass if MIN_COUNT<=each<=MAX_COUNT.
    - Pass: register into cal_h/cal_l, set cal_valid=1, cal_upd=1 for one cycle (the cycle after CHECK), go to DONE.
    - Fail: attempt fails (range).
  - Failed attempt:
    - If attempt<MAX_RETRY: attempt+=1, go to INIT.
    - Else: go to FAIL, with err_timeout or err_range set per the failure cause.
  - DONE:
    - meas_init=0; cal outputs held.
    - start re-enters INIT with attempt=0.
  - FAIL:
    - meas_init=1; err_* held.
    - start clears err_* and re-enters INIT with attempt=0.
- Timing:
  - start in cycle 0 puts the block in INIT in cycle 1; meas_init is high in cycles 1..INIT_CYCLES.
  - WAIT_LOCK begins in cycle INIT_CYCLES+1.
  - Lock sampled in cycle t gives CHECK at t+1, and cal_upd plus new cal_* at t+2.
- Recalibration:
  - cal_h/cal_l and cal_valid keep their previous values throughout; they change only on a passing CHECK.
  - A failed recal leaves the old values and cal_valid=1 in place.
- abort:
  - Any state goes to IDLE next cycle and timer clears.
  - cal_* and cal_valid are preserved; err_* are cleared.
- Arithmetic and widths:
  - The timer is unsigned TMRBW bits and saturates (never wraps).
  - Comparisons are unsigned COUNTBW bits.
- Input timing: meas_locked is synchronous to clk. meas_* are stable while meas_locked=1.

Optional Feature:
- Macro: PERIOD_CAL_AUTO_RECAL_EN.
- When defined:
  - In DONE the timer counts.
  - At timer==RECAL_PERIOD-1 the block starts a recal exactly as if start were asserted (attempt=0, go to INIT).
  - An explicit start in DONE restarts immediately and clears the timer.
- When undefined: DONE is held indefinitely until start or abort; the RECAL_PERIOD parameter is unused.

Test Plan:
- Bench parameters: INIT_CYCLES=4, LOCK_TIMEOUT=100, MAX_RETRY=2, MIN_COUNT=10, MAX_COUNT=1000.
- Nominal:
  - Stimulus: start at cycle 0; meas_locked=1 at cycle 20 with meas_h=400, meas_l=600.
  - Required: meas_init high cycles 1-4 and low from 5; cal_upd pulse at cycle 22; cal_h=400, cal_l=600, cal_valid=1, busy=0.
- Timeout exhaustion:
  - Stimulus: start; meas_locked held 0.
  - Required: three attempts of 4+100 cycles each; then FAIL with err_timeout=1, err_range=0, attempt=2, cal_valid=0, meas_init=1.
- Range retry then pass:
  - Stimulus: first lock with meas_h=5 (below MIN_COUNT); second lock with 500/500.
  - Required: attempt goes 0→1; cal_h=cal_l=500; err_range=0.
- Failed recal keeps old values:
  - Stimulus: after a pass with 400/600, start again; every attempt returns meas_l=2000.
  - Required: err_range=1; cal_h=400, cal_l=600, cal_valid=1 unchanged.
- Abort and reset:
  - Stimulus: abort mid-WAIT_LOCK.
  - Required: IDLE next cycle, meas_init=1, err_*=0.
  - Stimulus: rst_n low mid-INIT (asynchronous).
  - Required: all outputs at reset values with no clock edge.
- Lock/timeout tie:
  - Stimulus: meas_locked rises in the cycle where timer==99.
  - Required: goes to CHECK, no retry.
- With PERIOD_CAL_AUTO_RECAL_EN and RECAL_PERIOD=200:
  - Required: INIT re-entered 200 cycles after entering DONE.
